// File: rtl/isi_hist_accumulator.sv
// Read-modify-write ISI histogram accumulator with RAW forwarding and a histogram clear sweep.
// Optional macro HIST_ACC_SAT_EN: clamp sums to all-ones and raise sticky sat_flag; otherwise sums wrap.
module isi_hist_accumulator #(
    parameter int BIT_ISI = 8,
    parameter int BIT_ACC = 19,
    parameter int BIT_INC = 4,
    parameter int RD_LAT  = 1
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               in_valid,
    input  logic [BIT_ISI-1:0] in_addr,
    input  logic [BIT_INC-1:0] in_inc,
    output logic               in_ready,
    output logic               ram_re,
    output logic [BIT_ISI-1:0] ram_raddr,
    input  logic [BIT_ACC-1:0] ram_rdata,
    output logic               ram_we,
    output logic [BIT_ISI-1:0] ram_waddr,
    output logic [BIT_ACC-1:0] ram_wdata,
    input  logic               clear_req,
    output logic               clear_busy,
    output logic               clear_done,
    output logic               sat_flag
);
    localparam int HIST = RD_LAT + 1;
    localparam logic [BIT_ISI-1:0] LAST_ADDR = {BIT_ISI{1'b1}};
    localparam logic [BIT_ISI-1:0] ONE_ADDR  = {{(BIT_ISI-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CLEAR = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [BIT_ISI-1:0] sweep_q, sweep_d;

    logic [RD_LAT-1:0]  pv_q;
    logic [BIT_ISI-1:0] pa_q [RD_LAT];
    logic [BIT_INC-1:0] pi_q [RD_LAT];

    // hist entry 0 is the write stage itself; higher indices are older copies
    logic [HIST-1:0]    hv_q;
    logic [BIT_ISI-1:0] ha_q [HIST];
    logic [BIT_ACC-1:0] hd_q [HIST];

    logic               wv_d;
    logic [BIT_ISI-1:0] wa_d;
    logic [BIT_ACC-1:0] wd_d;

    logic               accept_s;
    logic               empty_s;
    logic               ex_v_s;
    logic [BIT_ISI-1:0] ex_a_s;
    logic [BIT_INC-1:0] ex_inc_s;
    logic [BIT_ACC-1:0] base_s;
    logic [BIT_ACC-1:0] ex_data_s;
    logic               busy_d, done_d;
    logic               clear_busy_q, clear_done_q;

    assign accept_s  = in_valid & in_ready;
    assign ram_re    = accept_s;
    assign ram_raddr = in_addr;

    assign ex_v_s   = pv_q[RD_LAT-1];
    assign ex_a_s   = pa_q[RD_LAT-1];
    assign ex_inc_s = pi_q[RD_LAT-1];
    assign empty_s  = ~(|pv_q) & ~hv_q[0];

    assign ram_we     = hv_q[0];
    assign ram_waddr  = ha_q[0];
    assign ram_wdata  = hd_q[0];
    assign clear_busy = clear_busy_q;
    assign clear_done = clear_done_q;

    // Base select: scan oldest to youngest so the youngest matching history entry wins
    always_comb begin
        base_s = ram_rdata;
        for (int k = HIST - 1; k >= 0; k--) begin
            base_s = (hv_q[k] && (ha_q[k] == ex_a_s)) ? hd_q[k] : base_s;
        end
    end

`ifdef HIST_ACC_SAT_EN
    logic [BIT_ACC:0] sum_s;
    logic             ovf_s;
    logic             sat_q, sat_d;

    // Saturating add at execute
    always_comb begin
        sum_s = {1'b0, base_s} + (BIT_ACC+1)'(ex_inc_s);
        if (sum_s[BIT_ACC]) begin
            ex_data_s = {BIT_ACC{1'b1}};
            ovf_s     = ex_v_s;
        end else begin
            ex_data_s = sum_s[BIT_ACC-1:0];
            ovf_s     = 1'b0;
        end
    end

    // Sticky saturation flag next state, dropped when the sweep completes
    always_comb begin
        if (state_d == ST_DONE) begin
            sat_d = 1'b0;
        end else if (ovf_s) begin
            sat_d = 1'b1;
        end else begin
            sat_d = sat_q;
        end
    end

    // Saturation flag register
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end

    assign sat_flag = sat_q;
`else
    logic [BIT_ACC-1:0] sum_s;

    // Wrapping add at execute
    always_comb begin
        sum_s     = base_s + BIT_ACC'(ex_inc_s);
        ex_data_s = sum_s;
    end

    assign sat_flag = 1'b0;
`endif

    // FSM state and sweep counter register
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= ST_RUN;
            sweep_q <= {BIT_ISI{1'b0}};
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        case (state_q)
            ST_RUN:   state_d = clear_req ? ST_DRAIN : ST_RUN;
            ST_DRAIN: state_d = empty_s ? ST_CLEAR : ST_DRAIN;
            ST_CLEAR: state_d = (sweep_q == LAST_ADDR) ? ST_DONE : ST_CLEAR;
            ST_DONE:  state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    // FSM outputs and write-stage source select (sweep zeros or execute result)
    always_comb begin
        in_ready = (state_q == ST_RUN);
        busy_d   = (state_d != ST_RUN);
        done_d   = (state_d == ST_DONE);
        if (state_q == ST_CLEAR) begin
            sweep_d = sweep_q + ONE_ADDR;
            wv_d    = 1'b1;
            wa_d    = sweep_q;
            wd_d    = {BIT_ACC{1'b0}};
        end else begin
            sweep_d = {BIT_ISI{1'b0}};
            wv_d    = ex_v_s;
            wa_d    = ex_a_s;
            wd_d    = ex_data_s;
        end
    end

    // Issue pipeline, write stage and forwarding history
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            pv_q <= {RD_LAT{1'b0}};
            hv_q <= {HIST{1'b0}};
            for (int k = 0; k < RD_LAT; k++) begin
                pa_q[k] <= {BIT_ISI{1'b0}};
                pi_q[k] <= {BIT_INC{1'b0}};
            end
            for (int k = 0; k < HIST; k++) begin
                ha_q[k] <= {BIT_ISI{1'b0}};
                hd_q[k] <= {BIT_ACC{1'b0}};
            end
        end else begin
            pv_q[0] <= accept_s;
            pa_q[0] <= in_addr;
            pi_q[0] <= in_inc;
            for (int k = 1; k < RD_LAT; k++) begin
                pv_q[k] <= pv_q[k-1];
                pa_q[k] <= pa_q[k-1];
                pi_q[k] <= pi_q[k-1];
            end
            hv_q[0] <= wv_d;
            ha_q[0] <= wa_d;
            hd_q[0] <= wd_d;
            for (int k = 1; k < HIST; k++) begin
                hv_q[k] <= hv_q[k-1];
                ha_q[k] <= ha_q[k-1];
                hd_q[k] <= hd_q[k-1];
            end
        end
    end

    // Clear status registers
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            clear_busy_q <= 1'b0;
            clear_done_q <= 1'b0;
        end else begin
            clear_busy_q <= busy_d;
            clear_done_q <= done_d;
        end
    end

endmodule

// File: tb/tb_isi_hist_accumulator.sv
// Self-checking bench for isi_hist_accumulator: RAM model, reference histogram and write scoreboard.
// Build with HIST_ACC_SAT_EN defined to check the saturating variant.
module tb_isi_hist_accumulator;
    localparam int BIT_ISI = 8;
    localparam int BIT_ACC = 19;
    localparam int BIT_INC = 4;
    localparam int RD_LAT  = 3;
    localparam int DEPTH   = 1 << BIT_ISI;
`ifdef HIST_ACC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        logic [7:0]  addr;
        logic [18:0] data;
        int          cyc;
    } wr_t;

    typedef struct {
        logic [7:0]  addr;
        logic [3:0]  inc;
        logic [18:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        clr;
    logic        in_valid, in_ready;
    logic [7:0]  in_addr;
    logic [3:0]  in_inc;
    logic        ram_re, ram_we;
    logic [7:0]  ram_raddr, ram_waddr;
    logic [18:0] ram_rdata, ram_wdata;
    logic        clear_req, clear_busy, clear_done, sat_flag;

    logic        pl_en;
    logic [7:0]  pl_addr;
    logic [18:0] pl_data;
    logic [18:0] mem [DEPTH];
    logic [18:0] rd_pipe [RD_LAT];
    logic [18:0] ref_hist [DEPTH];

    wr_t  sb [$];
    wr_t  mon_e;
    vec_t vecs [15];
    int   checks = 0;
    int   fails  = 0;
    int   cyc    = 0;

    isi_hist_accumulator #(
        .BIT_ISI(BIT_ISI), .BIT_ACC(BIT_ACC), .BIT_INC(BIT_INC), .RD_LAT(RD_LAT)
    ) u_dut (
        .clk(clk), .clr(clr),
        .in_valid(in_valid), .in_addr(in_addr), .in_inc(in_inc), .in_ready(in_ready),
        .ram_re(ram_re), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
        .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
        .clear_req(clear_req), .clear_busy(clear_busy), .clear_done(clear_done),
        .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous dual-port RAM, read-old-data, RD_LAT read latency
    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (ram_we) mem[ram_waddr] <= ram_wdata;
        if (ram_re) rd_pipe[0] <= mem[ram_raddr];
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign ram_rdata = rd_pipe[RD_LAT-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [18:0] acc(input logic [18:0] b, input logic [3:0] inc);
        logic [19:0] s;
        s = {1'b0, b} + {16'd0, inc};
        if (SAT && s[19]) return 19'h7FFFF;
        return s[18:0];
    endfunction

    // Drive one cycle of inputs at the falling edge; accepted samples go to the scoreboard
    task automatic drive(input logic v, input logic [7:0] a, input logic [3:0] inc,
                         input logic creq, input logic use_exp, input logic [18:0] exp);
        @(negedge clk);
        in_valid  = v;
        in_addr   = a;
        in_inc    = inc;
        clear_req = creq;
        #1;
        if (v) begin
            check("in_ready", in_ready, 1);
            check("ram_re", ram_re, 1);
            check("ram_raddr", ram_raddr, a);
            ref_hist[a] = use_exp ? exp : acc(ref_hist[a], inc);
            sb.push_back('{a, ref_hist[a], cyc + RD_LAT + 1});
        end else begin
            check("ram_re_idle", ram_re, 0);
        end
        if (creq) begin
            for (int k = 0; k < DEPTH; k++) begin
                sb.push_back('{8'(k), 19'd0, -1});
                ref_hist[k] = 19'd0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'd0, 4'd0, 1'b0, 1'b0, 19'd0);
    endtask

    task automatic preload(input logic [7:0] a, input logic [18:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        ref_hist[a] = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            #2;
            n++;
        end
        check("drain_pending_writes", sb.size(), 0);
    endtask

    // Write monitor: every RAM write must match the head of the scoreboard
    initial forever begin
        @(negedge clk);
        if (!clr && ram_we) begin
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", ram_waddr, ram_wdata);
            end else begin
                mon_e = sb.pop_front();
                check("wr_addr", ram_waddr, mon_e.addr);
                check("wr_data", ram_wdata, mon_e.data);
                if (mon_e.cyc >= 0) check("wr_cycle", cyc, mon_e.cyc);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        in_valid = 1'b0; in_addr = 8'd0; in_inc = 4'd0; clear_req = 1'b0;
        pl_en = 1'b0; pl_addr = 8'd0; pl_data = 19'd0;
        clr = 1'b1;

        for (int i = 0; i < 5; i++) vecs[i] = '{8'h12, 4'd1, 19'(i + 1)};
        vecs[5]  = '{8'h40, 4'd2, 19'd12};
        vecs[6]  = '{8'h41, 4'd2, 19'd12};
        vecs[7]  = '{8'h40, 4'd2, 19'd14};
        vecs[8]  = '{8'h41, 4'd2, 19'd14};
        vecs[9]  = '{8'h40, 4'd2, 19'd16};
        vecs[10] = '{8'h7F, 4'd3, SAT ? 19'h7FFFF : 19'h00001};
        vecs[11] = '{8'h7F, 4'd1, SAT ? 19'h7FFFF : 19'h00002};
        vecs[12] = '{8'h00, 4'd15, 19'h14};
        vecs[13] = '{8'hFF, 4'd0, 19'h123};
        vecs[14] = '{8'hFF, 4'd1, 19'h124};

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_ram_we", ram_we, 0);
        check("rst_ram_waddr", ram_waddr, 0);
        check("rst_ram_wdata", ram_wdata, 0);
        check("rst_clear_busy", clear_busy, 0);
        check("rst_clear_done", clear_done, 0);
        check("rst_sat_flag", sat_flag, 0);
        @(negedge clk);
        clr = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);

        for (int k = 0; k < DEPTH; k++) begin
            @(negedge clk);
            pl_en = 1'b1; pl_addr = 8'(k); pl_data = 19'd0;
            ref_hist[k] = 19'd0;
        end
        @(negedge clk);
        pl_en = 1'b0;

        // Table vectors: same-bin streak, A/B hazards, overflow, boundary bins
        preload(8'h40, 19'd10);
        preload(8'h41, 19'd10);
        preload(8'h7F, 19'h7FFFE);
        preload(8'h00, 19'd5);
        preload(8'hFF, 19'h123);
        foreach (vecs[i]) drive(1'b1, vecs[i].addr, vecs[i].inc, 1'b0, 1'b1, vecs[i].exp);
        idle(1);
        wait_drain(50);
        check("sat_flag_after_overflow", sat_flag, SAT);

        // Clear request with three samples in flight
        drive(1'b1, 8'h05, 4'd3, 1'b0, 1'b0, 19'd0);
        drive(1'b1, 8'h06, 4'd4, 1'b0, 1'b0, 19'd0);
        drive(1'b1, 8'hFF, 4'd2, 1'b1, 1'b0, 19'd0);
        idle(1);
        check("clear_busy_after_req", clear_busy, 1);
        check("in_ready_busy", in_ready, 0);
        @(negedge clk);
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        n = 0;
        while (n < 600) begin
            @(negedge clk);
            #2;
            if (clear_done) break;
            n++;
        end
        check("clear_done_seen", clear_done, 1);
        check("done_last_waddr", ram_waddr, 8'hFF);
        check("done_last_we", ram_we, 1);
        check("done_writes_complete", sb.size(), 0);
        check("done_clear_busy", clear_busy, 1);
        check("done_sat_flag", sat_flag, 0);
        drive(1'b1, 8'hFF, 4'd7, 1'b0, 1'b0, 19'd0);
        check("after_done_clear_done", clear_done, 0);
        check("after_done_clear_busy", clear_busy, 0);
        idle(1);
        wait_drain(50);

        // Reset mid-stream, then verify no stale forwarding
        preload(8'h30, 19'd50);
        for (int i = 0; i < 6; i++) drive(1'b1, 8'h30, 4'd5, 1'b0, 1'b0, 19'd0);
        #1;
        clr = 1'b1;
        in_valid = 1'b0;
        #1;
        check("clr_ram_we", ram_we, 0);
        check("clr_ram_wdata", ram_wdata, 0);
        repeat (2) @(negedge clk);
        clr = 1'b0;
        sb.delete();
        #1;
        check("post_clr_in_ready", in_ready, 1);
        preload(8'h30, 19'd100);
        drive(1'b1, 8'h30, 4'd1, 1'b0, 1'b0, 19'd0);
        drive(1'b1, 8'h31, 4'd2, 1'b0, 1'b0, 19'd0);
        drive(1'b1, 8'h30, 4'd3, 1'b0, 1'b0, 19'd0);
        idle(1);
        wait_drain(50);

        // Random stream biased to a few bins for dense hazards
        for (int i = 0; i < 3000; i++) begin
            logic       v;
            logic [7:0] a;
            v = ($urandom_range(0, 3) != 0);
            a = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255));
            drive(v, a, 4'($urandom_range(0, 15)), 1'b0, 1'b0, 19'd0);
        end
        idle(1);
        wait_drain(50);
        idle(2);
        for (int k = 0; k < DEPTH; k++) check("final_bin", mem[k], ref_hist[k]);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
